// File: rtl/four_bit_sub.sv
// 4-bit ripple-borrow subtractor {bout, D} = a - b - bin, with a 1-cycle registered copy.
// Optional signed-overflow outputs ovf/ovf_r are present only when FOURBITSUB_OVF_EN is defined.
module four_bit_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] D,
  output logic       bout,
  output logic [3:0] D_r,
  output logic       bout_r
`ifdef FOURBITSUB_OVF_EN
  ,
  output logic       ovf,
  output logic       ovf_r
`endif
);

  // One variable per stage borrow so the ripple chain is not a self-referencing vector.
  logic br [0:4];
  logic [3:0] diff;

  assign br[0] = bin;

  for (genvar i = 0; i < 4; i++) begin : g_stage
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign D    = diff;
  assign bout = br[4];

  logic [3:0] d_q;
  logic [3:0] d_d;
  logic       bout_q;
  logic       bout_d;

  assign d_d    = diff;
  assign bout_d = br[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= 4'b0000;
      bout_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      bout_q <= bout_d;
    end
  end

  assign D_r    = d_q;
  assign bout_r = bout_q;

`ifdef FOURBITSUB_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into and out of the sign bit disagree exactly on two's-complement overflow.
  assign ovf_d = br[3] ^ br[4];
  assign ovf   = ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_r = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_sub.sv
// Self-checking bench for four_bit_sub: directed, reset, exhaustive and random vectors
// against an integer-arithmetic reference model.
module tb_four_bit_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic [3:0] D;
  logic       bout;
  logic [3:0] D_r;
  logic       bout_r;
`ifdef FOURBITSUB_OVF_EN
  logic       ovf;
  logic       ovf_r;
`endif

  int checks = 0;
  int errors = 0;

  four_bit_sub dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .D      (D),
    .bout   (bout),
    .D_r    (D_r),
    .bout_r (bout_r)
`ifdef FOURBITSUB_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_r  (ovf_r)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[4:0];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] x, input logic [3:0] y, input logic c);
    int sx;
    int sy;
    int r;
    sx = $signed(x);
    sy = $signed(y);
    r  = sx - sy - int'(c);
    return (r < -8) || (r > 7);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a vector between edges, check combinational outputs, then the registered copy.
  task automatic run_vec(input string tag, input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] e;
    e = ref_sub(x, y, c);
    @(negedge clk);
    a = x; b = y; bin = c;
    #1;
    chk({tag, "_comb"}, {3'b0, bout, D}, {3'b0, e});
`ifdef FOURBITSUB_OVF_EN
    chk({tag, "_ovf"}, {7'b0, ovf}, {7'b0, ref_ovf(x, y, c)});
`endif
    @(posedge clk);
    #1;
    chk({tag, "_reg"}, {3'b0, bout_r, D_r}, {3'b0, e});
`ifdef FOURBITSUB_OVF_EN
    chk({tag, "_ovf_r"}, {7'b0, ovf_r}, {7'b0, ref_ovf(x, y, c)});
`endif
  endtask

  initial begin
    rst = 1'b1; a = 4'd0; b = 4'd0; bin = 1'b0;
    #2;
    chk("reset_D_r", {4'b0, D_r}, 8'h00);
    chk("reset_bout_r", {7'b0, bout_r}, 8'h00);
`ifdef FOURBITSUB_OVF_EN
    chk("reset_ovf_r", {7'b0, ovf_r}, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_vec("eq_zero",   4'b0011, 4'b0011, 1'b0);
    run_vec("eleven",    4'b1011, 4'b0111, 1'b1);
    run_vec("wrap_ff1",  4'b1111, 4'b1111, 1'b1);
    run_vec("wrap_01",   4'b0000, 4'b0001, 1'b0);
    run_vec("wrap_001",  4'b0000, 4'b0000, 1'b1);
    run_vec("neg_ovf",   4'b1000, 4'b0001, 1'b0);
    run_vec("pos_ovf",   4'b0111, 4'b1000, 1'b0);
    run_vec("max_min",   4'b1111, 4'b0000, 1'b0);

    // Mid-cycle reset clears the registers at once but leaves the datapath alone.
    run_vec("pre_rst",   4'b0101, 4'b0001, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_D_r", {4'b0, D_r}, 8'h00);
    chk("rst_async_bout_r", {7'b0, bout_r}, 8'h00);
    chk("rst_D_held", {3'b0, bout, D}, 8'h04);
    @(posedge clk);
    #1;
    chk("rst_hold_D_r", {4'b0, D_r}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_no_edge", {4'b0, D_r}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_resume_D_r", {3'b0, bout_r, D_r}, 8'h04);

    // Exhaustive sweep of the combinational path.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a = v[3:0]; b = v[7:4]; bin = v[8];
      #1;
      chk("exhaustive", {3'b0, bout, D}, {3'b0, ref_sub(v[3:0], v[7:4], v[8])});
`ifdef FOURBITSUB_OVF_EN
      chk("exhaustive_ovf", {7'b0, ovf}, {7'b0, ref_ovf(v[3:0], v[7:4], v[8])});
`endif
    end

    for (int i = 0; i < 200; i++) begin
      logic [31:0] r;
      r = $urandom;
      run_vec("random", r[3:0], r[7:4], r[8]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
